uart_bus_port: RTL and testbench

Memory-mapped UART peripheral on the processor's shared 64-bit data/address bus, alongside the GPU, keyboard converter and GPIO blocks. Drains bytes written by the processor through an 8-entry TX FIFO onto `uart_txd`. Receives bytes from `uart_rxd` into a single holding register that the processor polls and reads. Sits directly downstream of the processor on the bus and drives the board's RS-232 pins.

---
 rtl/uart_bus_port.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_bus_port.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_port.sv
// Memory-mapped UART on the shared 64-bit bus: DATA/STATUS registers, a TX FIFO
// draining onto uart_txd, and a single polled RX holding register fed from uart_rxd.
module uart_bus_port #(
   parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0000_1000,
   parameter int unsigned CLOCKS_PER_BIT = 217,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   inout  wire  [63:0] data,
   input  logic [63:0] address,
   input  logic        read,
   input  logic        write,
   input  logic        uart_rxd,
   input  logic        uart_rts,
   output logic        uart_txd,
   output logic        uart_cts
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BIT_W = $clog2(CLOCKS_PER_BIT);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   // ---------------- bus decode and access edges ----------------
   logic hit_data, hit_stat;
   logic read_q, write_q;
   logic rd_data_evt, wr_data_evt, wr_stat_evt;
   logic unused_bus;

   assign hit_data    = (address == BASE_ADDR);
   assign hit_stat    = (address == BASE_ADDR + 64'd1);
   assign rd_data_evt = read & ~read_q & hit_data;
   assign wr_data_evt = write & ~write_q & hit_data;
   assign wr_stat_evt = write & ~write_q & hit_stat;
   assign unused_bus  = ^data[63:8];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end else begin
         read_q  <= read;
         write_q <= write;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             tx_full, tx_empty, push, pop;
   tx_state_e        tx_state_q, tx_state_d;

   assign tx_full  = (count_q == FIFO_FULL);
   assign tx_empty = (count_q == '0);
   assign pop      = (tx_state_q == TxIdle) && !tx_empty && uart_rts;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = wr_data_evt && (!tx_full || pop);

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_q] <= data[7:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // ---------------- TX FSM ----------------
   logic [BIT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + BIT_W'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TxIdle: begin
            tx_cnt_d = '0;
            if (pop) begin
               tx_state_d = TxStart;
               tx_shift_d = fifo_mem[rd_ptr_q];
            end
         end
         TxStart: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = TxData;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end
         end
         TxData: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            end
         end
         TxStop: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = TxIdle;
               tx_cnt_d   = '0;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   // Decoded straight from state so reset forces the line high without a clock.
   always_comb begin
      uart_txd = 1'b1;
      case (tx_state_q)
         TxStart: uart_txd = 1'b0;
         TxData:  uart_txd = tx_shift_q[0];
         default: uart_txd = 1'b1;
      endcase
   end

   // ---------------- RX synchronizer and FSM ----------------
   logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [BIT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_done;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_s3_q   <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rxd_s1_q   <= uart_rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_s3_q   <= rxd_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + BIT_W'(1);
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rxd_s3_q && !rxd_s2_q) rx_state_d = RxStart;
         end
         RxStart: begin
            // Mid start bit: a line already back high was only a glitch.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_s2_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_done    = 1'b1;
               rx_state_d = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // ---------------- RX holding register and flags ----------------
   logic       rx_valid_q, rx_valid_d;
   logic       rx_overrun_q, rx_overrun_d;
   logic       framing_error_q, framing_error_d;
   logic [7:0] rx_byte_q, rx_byte_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_valid_q      <= 1'b0;
         rx_overrun_q    <= 1'b0;
         framing_error_q <= 1'b0;
         rx_byte_q       <= '0;
      end else begin
         rx_valid_q      <= rx_valid_d;
         rx_overrun_q    <= rx_overrun_d;
         framing_error_q <= framing_error_d;
         rx_byte_q       <= rx_byte_d;
      end
   end

   // Clears are applied first so a same-cycle DATA read and completion reload cleanly.
   always_comb begin
      rx_valid_d      = rx_valid_q & ~rd_data_evt;
      rx_overrun_d    = rx_overrun_q & ~(wr_stat_evt & data[4]);
      framing_error_d = framing_error_q & ~(wr_stat_evt & data[5]);
      rx_byte_d       = rx_byte_q;
      if (rx_done) begin
         if (!rxd_s2_q) begin
            framing_error_d = 1'b1;
         end else if (rx_valid_d) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   assign uart_cts = ~rx_valid_q;

   // ---------------- read mux and bus driver ----------------
   logic [63:0] status_word, rdata;

   always_comb begin
      status_word              = '0;
      status_word[0]           = tx_full;
      status_word[1]           = tx_empty;
      status_word[2]           = (tx_state_q != TxIdle);
      status_word[3]           = rx_valid_q;
      status_word[4]           = rx_overrun_q;
      status_word[5]           = framing_error_q;
      status_word[8 +: CNT_W]  = count_q;
   end

   assign rdata = hit_data ? {56'b0, rx_byte_q} : status_word;
   assign data  = (read && (hit_data || hit_stat)) ? rdata : {64{1'bz}};

endmodule

// File: tb/tb_uart_bus_port.sv
// Self-checking bench for uart_bus_port: vector table, hand-timed TX/RX corner
// sequences and randomized traffic checked against a queue-based model.
module tb_uart_bus_port;

   localparam int unsigned CPB     = 4;
   localparam logic [63:0] BASE    = 64'h0000_0000_0000_1000;
   localparam logic [63:0] STAT    = BASE + 64'd1;
   localparam logic [63:0] PATTERN = 64'hA5A5_5A5A_C3C3_3C3C;
   localparam int          FRAME   = 10 * CPB + 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        uart_rxd = 1'b1;
   logic        uart_rts = 1'b0;
   logic        uart_txd, uart_cts;
   logic        tb_en = 1'b0;
   logic [63:0] tb_val = '0;
   wire  [63:0] bus;

   assign bus = tb_en ? tb_val : {64{1'bz}};

   always #5 clock = ~clock;

   uart_bus_port #(
      .BASE_ADDR      (BASE),
      .CLOCKS_PER_BIT (CPB),
      .FIFO_DEPTH     (8)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .data     (bus),
      .address  (address),
      .read     (read),
      .write    (write),
      .uart_rxd (uart_rxd),
      .uart_rts (uart_rts),
      .uart_txd (uart_txd),
      .uart_cts (uart_cts)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [7:0] exp_tx [$];
   logic [8:0] got_tx [$];
   logic       rx_valid_m = 1'b0;
   logic       ov_m = 1'b0;
   logic       fe_m = 1'b0;
   logic [7:0] rx_byte_m = '0;

   typedef struct {
      int          op;    // 0 write, 1 read, 2 unmapped read, 3 idle float
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl [$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_status();
      return {58'b0, fe_m, ov_m, rx_valid_m, 3'b010};
   endfunction

   // Accepted only while fewer than 8 bytes are still waiting to leave the wire.
   task automatic model_push(input logic [7:0] b);
      if (exp_tx.size() - got_tx.size() < 8) exp_tx.push_back(b);
   endtask

   function automatic void rx_model(input logic [7:0] b, input logic stop);
      if (!stop) fe_m = 1'b1;
      else if (rx_valid_m) ov_m = 1'b1;
      else begin
         rx_byte_m  = b;
         rx_valid_m = 1'b1;
      end
   endfunction

   task automatic bus_write(input logic [63:0] addr, input logic [63:0] val, input int hold);
      @(negedge clock);
      address = addr;
      tb_val  = val;
      tb_en   = 1'b1;
      write   = 1'b1;
      repeat (hold) @(negedge clock);
      write = 1'b0;
      tb_en = 1'b0;
   endtask

   task automatic bus_read(input logic [63:0] addr, input logic [63:0] exp, input string name);
      @(negedge clock);
      address = addr;
      read    = 1'b1;
      #1;
      check(name, bus, exp);
      @(negedge clock);
      read = 1'b0;
   endtask

   // Bench drives a pattern; any DUT drive would corrupt it.
   task automatic float_check(input logic [63:0] addr, input logic rd, input string name);
      @(negedge clock);
      address = addr;
      read    = rd;
      tb_val  = PATTERN;
      tb_en   = 1'b1;
      #1;
      check(name, bus, PATTERN);
      @(negedge clock);
      read  = 1'b0;
      tb_en = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clock);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clock);
      end
      uart_rxd = stop;
      repeat (CPB) @(negedge clock);
      uart_rxd = 1'b1;
      repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic check_tx_frames();
      logic [7:0] e;
      logic [8:0] g;
      while (exp_tx.size() > 0) begin
         e = exp_tx.pop_front();
         if (got_tx.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_frame_missing: got none expected %h", e);
         end else begin
            g = got_tx.pop_front();
            check("tx_frame", {55'b0, g}, {55'b0, 1'b1, e});
         end
      end
      check("tx_extra_frames", 64'(got_tx.size()), 64'd0);
      got_tx.delete();
   endtask

   // TX line monitor: samples each bit CPB clocks apart from the first low sample.
   initial begin
      logic [7:0] mb;
      forever begin
         @(negedge clock);
         if (reset_n && uart_txd === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               mb[i] = uart_txd;
            end
            repeat (CPB) @(negedge clock);
            got_tx.push_back({uart_txd, mb});
         end
      end
   end

   initial begin
      logic [9:0] fr;
      logic [7:0] b;
      int         n;
      logic       stop;

      // Reset state
      repeat (2) @(negedge clock);
      check("reset_txd", {63'b0, uart_txd}, 64'd1);
      check("reset_cts", {63'b0, uart_cts}, 64'd1);
      reset_n = 1'b1;

      // Vector table, uart_rts low so nothing drains
      tbl.push_back('{1, STAT, 64'd0, 64'h2});
      tbl.push_back('{3, BASE, 64'd0, PATTERN});
      tbl.push_back('{2, BASE + 64'd2, 64'd0, PATTERN});
      for (int i = 0; i < 10; i++)
         tbl.push_back('{0, BASE, 64'hFFFF_0000_1234_5600 | 64'(8'h10 + i), 64'd0});
      tbl.push_back('{1, STAT, 64'd0, 64'h801});
      tbl.push_back('{1, BASE, 64'd0, 64'h0});

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].op)
            0: begin
               bus_write(tbl[i].addr, tbl[i].wdata, 1);
               model_push(tbl[i].wdata[7:0]);
            end
            1: bus_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d_read", i));
            2: float_check(tbl[i].addr, 1'b1, $sformatf("vec%0d_unmapped", i));
            default: float_check(tbl[i].addr, 1'b0, $sformatf("vec%0d_no_read", i));
         endcase
      end

      uart_rts = 1'b1;
      repeat (8 * FRAME + 20) @(negedge clock);
      check_tx_frames();
      bus_read(STAT, 64'h2, "status_drained");

      // 8'hA5 with write held 3 cycles: exactly one frame, start bit 1 clock after push
      fr = {1'b1, 8'hA5, 1'b0};
      @(negedge clock);
      address = BASE;
      tb_val  = 64'hDEAD_BEEF_0000_00A5;
      tb_en   = 1'b1;
      write   = 1'b1;
      model_push(8'hA5);
      for (int k = 0; k < 42; k++) begin
         @(negedge clock);
         check($sformatf("a5_txd_k%0d", k), {63'b0, uart_txd},
               {63'b0, (k == 0 || k == 41) ? 1'b1 : fr[(k - 1) / 4]});
         if (k == 2) begin
            write = 1'b0;
            tb_en = 1'b0;
         end
      end
      repeat (3 * FRAME) @(negedge clock);
      check_tx_frames();

      // RX 8'h3C, read it back
      send_rx(8'h3C, 1'b1);
      rx_model(8'h3C, 1'b1);
      bus_read(STAT, exp_status(), "rx_3c_status");
      check("rx_3c_cts", {63'b0, uart_cts}, 64'd0);
      bus_read(BASE, 64'h3C, "rx_3c_data");
      rx_valid_m = 1'b0;
      bus_read(STAT, exp_status(), "rx_3c_status_after");
      check("rx_3c_cts_after", {63'b0, uart_cts}, 64'd1);

      // Overrun keeps the first byte
      send_rx(8'h81, 1'b1);
      rx_model(8'h81, 1'b1);
      send_rx(8'h7E, 1'b1);
      rx_model(8'h7E, 1'b1);
      bus_read(STAT, exp_status(), "overrun_status");
      bus_read(BASE, {56'b0, rx_byte_m}, "overrun_data");
      rx_valid_m = 1'b0;
      bus_write(STAT, 64'h10, 1);
      ov_m = 1'b0;
      bus_read(STAT, exp_status(), "overrun_cleared");

      // Framing error
      send_rx(8'h55, 1'b0);
      rx_model(8'h55, 1'b0);
      bus_read(STAT, exp_status(), "framing_status");
      bus_write(STAT, 64'h20, 1);
      fe_m = 1'b0;
      bus_read(STAT, exp_status(), "framing_cleared");

      // One-clock glitch
      @(negedge clock);
      uart_rxd = 1'b0;
      @(negedge clock);
      uart_rxd = 1'b1;
      repeat (12 * CPB) @(negedge clock);
      bus_read(STAT, exp_status(), "glitch_status");
      bus_read(BASE, {56'b0, rx_byte_m}, "glitch_data");

      // Randomized traffic against the model
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               n = $urandom_range(1, 4);
               for (int j = 0; j < n; j++) begin
                  b = 8'($urandom);
                  bus_write(BASE, {32'($urandom), 24'($urandom), b}, $urandom_range(1, 3));
                  model_push(b);
               end
               repeat (n * FRAME + 20) @(negedge clock);
               check_tx_frames();
               bus_read(STAT, exp_status(), "rand_tx_status");
            end
            1: begin
               b    = 8'($urandom);
               stop = ($urandom_range(0, 3) != 0);
               send_rx(b, stop);
               rx_model(b, stop);
               bus_read(STAT, exp_status(), "rand_rx_status");
               check("rand_rx_cts", {63'b0, uart_cts}, {63'b0, ~rx_valid_m});
            end
            default: begin
               bus_read(BASE, {56'b0, rx_byte_m}, "rand_data");
               rx_valid_m = 1'b0;
               if ($urandom_range(0, 1) == 1) begin
                  bus_write(STAT, 64'hFFFF_FFFF_FFFF_FFF0 | 64'h30, 1);
                  fe_m = 1'b0;
                  ov_m = 1'b0;
               end
               bus_read(STAT, exp_status(), "rand_status");
            end
         endcase
      end

      // Reset asserted mid-frame forces uart_txd high at once
      bus_write(BASE, 64'h0, 1);
      repeat (10) @(negedge clock);
      check("txd_mid_frame", {63'b0, uart_txd}, 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("txd_async_reset", {63'b0, uart_txd}, 64'd1);
      check("cts_async_reset", {63'b0, uart_cts}, 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      bus_read(STAT, 64'h2, "status_after_reset");
      bus_read(BASE, 64'h0, "data_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
